// File: rtl/vm_pkg.sv
// vm_pkg
// Shared definitions for the water-bottle vending machine.
// The 2-bit coin codes are common to the coin sequencer and the
// vending-machine FSM. The sequencer state type is defined here as well.
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        BURST   = 2'b10
    } seq_state_t;

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce
// Conditions one raw coin-sensor line: a 2-flop synchroniser, then a
// debounce counter that moves the debounced level only after
// DEBOUNCE_CYCLES consecutive samples disagree with it. It then emits a
// one-cycle pulse on every debounced 0->1 transition.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous, active-low reset
//   raw   - asynchronous, bouncy sensor input
//   pulse - one-cycle coin event on the debounced rising edge
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The synchroniser, the debounce counter and the delayed level used
    // for edge detection.
    // The counter holds the number of consecutive samples that disagree
    // with the current level. A sample that agrees with the level, which
    // happens on every bounce back, clears the counter. The sample that
    // would bring the count to DEBOUNCE_CYCLES commits the new level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/coin_sequencer.sv
// coin_sequencer
// Front end of the vending machine. It debounces the Rs. 5 and Rs. 10
// sensors and queues the accepted coins in a small FIFO. When the
// transaction closes on an idle timeout or a full queue, it replays the
// queued coins to the vending-machine FSM on consecutive cycles. One
// no-coin cycle follows the replay.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous, active-low reset
//   coin_5_raw  - raw Rs. 5 sensor
//   coin_10_raw - raw Rs. 10 sensor
//   vm_in       - registered coin code to the FSM (00 none, 01 Rs5, 10 Rs10)
//   busy        - high while collecting or replaying
//   coin_reject - one-cycle pulse to the return-chute solenoid
//   fifo_count  - current queue occupancy
module coin_sequencer
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          coin_5_raw,
    input  logic                          coin_10_raw,
    output logic [1:0]                    vm_in,
    output logic                          busy,
    output logic                          coin_reject,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          ev5;
    logic          ev10;
    logic          ev_one;
    logic          ev_both;
    logic [1:0]    ev_code;

    logic [1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          full;
    logic          empty;
    logic [1:0]    head;

    seq_state_t    state;
    seq_state_t    state_n;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_n;
    logic [1:0]    vm_in_n;
    logic          reject_n;
    logic          push;
    logic          pop;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk   (clk),
        .rst   (rst),
        .raw   (coin_5_raw),
        .pulse (ev5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk   (clk),
        .rst   (rst),
        .raw   (coin_10_raw),
        .pulse (ev10)
    );

    assign ev_one  = ev5 ^ ev10;
    assign ev_both = ev5 & ev10;
    assign ev_code = ev5 ? COIN_5 : COIN_10;

    assign full       = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty      = (wptr == rptr);
    assign head       = mem[rptr[AW-1:0]];
    assign fifo_count = wptr - rptr;
    assign busy       = (state != IDLE);

    // Next-state logic and sequencing.
    // vm_in is registered. The edge that enters BURST therefore already
    // loads the FIFO head and pops, so the first coin is visible in the
    // first BURST cycle. Any event is rejected when the queue is full or
    // during BURST, so a push and a pop never coincide.
    // A simultaneous event pair is rejected and counts as an idle cycle
    // for the timeout.
    always_comb begin
        state_n  = state;
        tcnt_n   = tcnt;
        vm_in_n  = COIN_NONE;
        reject_n = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (ev_both) begin
                    reject_n = 1'b1;
                end else if (ev_one) begin
                    push    = 1'b1;
                    tcnt_n  = '0;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (full) begin
                    reject_n = ev5 | ev10;
                    vm_in_n  = head;
                    pop      = 1'b1;
                    state_n  = BURST;
                end else if (ev_one) begin
                    push   = 1'b1;
                    tcnt_n = '0;
                end else begin
                    reject_n = ev_both;
                    if (tcnt == T_LAST) begin
                        vm_in_n = head;
                        pop     = 1'b1;
                        state_n = BURST;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            BURST: begin
                reject_n = ev5 | ev10;
                if (!empty) begin
                    vm_in_n = head;
                    pop     = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, timeout counter, queue pointers and registered outputs.
    // A reset flushes the queue by clearing both pointers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            tcnt        <= '0;
            wptr        <= '0;
            rptr        <= '0;
            vm_in       <= COIN_NONE;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_n;
            tcnt        <= tcnt_n;
            vm_in       <= vm_in_n;
            coin_reject <= reject_n;
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Queue storage. Stale entries are harmless because the pointers
    // define what is valid, so the storage has no reset.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wptr[AW-1:0]] <= ev_code;
        end
    end

    // The sequencing never requests a push and a pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_no_push_pop: assert (!(push && pop));
        end
    end

endmodule
